// File: rtl/sd_fifo_b_core.sv
// Memory-array srdy/drdy FIFO with optional packet commit/abort on each side.
// Reader prefetches into an output register so the FIFO sustains one word per cycle.
module sd_fifo_b_core #(
    parameter int unsigned width       = 8,
    parameter int unsigned depth       = 256,
    localparam int unsigned asz        = $clog2(depth),
    parameter bit          c_commit_en = 1'b0,
    parameter bit          p_commit_en = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic             c_commit,
    input  logic             c_abort,
    input  logic [width-1:0] c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    input  logic             p_commit,
    input  logic             p_abort,
    output logic [width-1:0] p_data,
    output logic [asz:0]     usage
);

    localparam logic [asz:0] PTR_ONE = {{asz{1'b0}}, 1'b1};
    localparam logic [asz:0] DEPTH_P = {1'b1, {asz{1'b0}}};

    logic [width-1:0] mem [depth];

    logic [asz:0]     wr_ptr_q, wr_ptr_d;
    logic [asz:0]     wr_com_q, wr_com_d;
    logic [asz:0]     rd_ptr_q, rd_ptr_d;
    logic [asz:0]     rd_com_q, rd_com_d;
    logic             dval_q, dval_d;
    logic [width-1:0] dout_q;

    logic             c_abt, c_cmt, p_abt, p_cmt;
    logic             full, wr_en, p_xfer, load;
    logic [asz:0]     consumed;

    // With the enables off these collapse to constants, so X on the pins is harmless.
    assign c_abt = c_commit_en && c_abort;
    assign c_cmt = !c_commit_en || c_commit;
    assign p_abt = p_commit_en && p_abort;
    assign p_cmt = !p_commit_en || p_commit;

    assign full     = (wr_ptr_q - rd_com_q) == DEPTH_P;
    assign c_drdy   = !reset && !full;
    assign wr_en    = c_srdy && c_drdy && !c_abt;
    assign p_xfer   = dval_q && p_drdy;
    // Output register holds the word at rd_ptr-1, so it is not yet consumed.
    assign consumed = rd_ptr_q - {{asz{1'b0}}, dval_q} + {{asz{1'b0}}, p_xfer};
    assign load     = !p_abt && (!dval_q || p_xfer) && (rd_ptr_q != wr_com_q);

    assign p_srdy = dval_q;
    assign p_data = dout_q;
    assign usage  = wr_com_q - rd_com_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_com_d = wr_com_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (c_abt) begin
            wr_ptr_d = wr_com_q;
        end else if (c_cmt) begin
            wr_com_d = wr_ptr_d;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        rd_com_d = rd_com_q;
        dval_d   = dval_q;
        if (p_abt) begin
            rd_ptr_d = rd_com_q;
            dval_d   = 1'b0;
        end else begin
            if (load) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dval_d   = 1'b1;
            end else if (p_xfer) begin
                dval_d = 1'b0;
            end
            if (p_cmt) begin
                rd_com_d = consumed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            wr_com_q <= '0;
            rd_ptr_q <= '0;
            rd_com_q <= '0;
            dval_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_com_q <= wr_com_d;
            rd_ptr_q <= rd_ptr_d;
            rd_com_q <= rd_com_d;
            dval_q   <= dval_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[asz-1:0]] <= c_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else if (load) begin
            dout_q <= mem[rd_ptr_q[asz-1:0]];
        end
    end

endmodule

// File: tb/tb_sd_fifo_b_core.sv
// Bench for sd_fifo_b_core: queue-based occupancy/visibility model checked every cycle,
// incrementing-byte generator and sequence checker, plus directed commit/abort steps.
module tb_sd_fifo_b_core;

    localparam int unsigned DEPTH = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    always #5 clk = ~clk;

    logic       c_srdy = 1'b0, c_drdy, p_srdy, p_drdy = 1'b0;
    logic       x_commit = 1'b0, x_abort = 1'b0, x_pcommit = 1'b0, x_pabort = 1'b0;
    logic [7:0] c_data = '0, p_data;
    logic [8:0] usage;

    logic       cc_srdy = 1'b0, cc_drdy, cc_commit = 1'b0, cc_abort = 1'b0;
    logic       cp_srdy, cp_drdy = 1'b0, cp_commit = 1'b0, cp_abort = 1'b0;
    logic [7:0] cc_data = '0, cp_data;
    logic [4:0] cc_usage;

    sd_fifo_b_core #(.width(8), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_commit(x_commit), .c_abort(x_abort), .c_data(c_data),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_commit(x_pcommit), .p_abort(x_pabort), .p_data(p_data),
        .usage(usage)
    );

    sd_fifo_b_core #(.width(8), .depth(16), .c_commit_en(1'b1), .p_commit_en(1'b1)) dut_c (
        .clk(clk), .reset(reset),
        .c_srdy(cc_srdy), .c_drdy(cc_drdy), .c_commit(cc_commit), .c_abort(cc_abort), .c_data(cc_data),
        .p_srdy(cp_srdy), .p_drdy(cp_drdy), .p_commit(cp_commit), .p_abort(cp_abort), .p_data(cp_data),
        .usage(cc_usage)
    );

    int unsigned n_pass = 0, n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: words accepted but not yet consumed, tagged with the edge that wrote them.
    typedef struct { logic [7:0] d; int unsigned wc; } ent_t;
    ent_t        q[$];
    int unsigned edge_n = 0;
    bit          m_psrdy = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        bit wr, rd;
        edge_n++;
        if (reset) begin
            q.delete();
            m_psrdy = 1'b0;
        end else begin
            wr = c_srdy && (q.size() < DEPTH);
            rd = p_drdy && m_psrdy;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back('{c_data, edge_n});
            m_psrdy = (q.size() > 0) && (q[0].wc < edge_n);
        end
    end

    int unsigned max_use = 0, min_use = 0, cdrdy_low = 0, psrdy_low = 0, full_block = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("c_drdy", 32'(c_drdy), 32'(!reset && (q.size() < DEPTH)));
            check("p_srdy", 32'(p_srdy), 32'(m_psrdy));
            check("usage", 32'(usage), 32'(q.size()));
            if (m_psrdy) check("p_data", 32'(p_data), 32'(q[0].d));
            if (!reset) begin
                if (32'(usage) > max_use) max_use = 32'(usage);
                if (32'(usage) < min_use) min_use = 32'(usage);
                if (!c_drdy) cdrdy_low++;
                if (!p_srdy) psrdy_low++;
                if (usage == 9'd256 && !c_drdy && c_srdy) full_block++;
            end
        end
    end

    task automatic clear_stats();
        max_use = 0; min_use = 999; cdrdy_low = 0; psrdy_low = 0; full_block = 0;
    endtask

    logic [7:0]  gen_cnt = '0, exp_seq = '0;
    int unsigned n_wr = 0, n_rd = 0;

    task automatic run(input logic [7:0] spat, input logic [7:0] dpat, input int unsigned n);
        bit acc, take;
        for (int unsigned i = 0; i < n; i++) begin
            c_srdy    = spat[i % 8];
            p_drdy    = dpat[i % 8];
            c_data    = gen_cnt;
            x_commit  = 1'($urandom_range(0, 1));
            x_abort   = 1'($urandom_range(0, 1));
            x_pcommit = 1'($urandom_range(0, 1));
            x_pabort  = 1'($urandom_range(0, 1));
            #1;
            acc  = c_srdy && c_drdy;
            take = p_srdy && p_drdy;
            if (take) begin
                check("seq", 32'(p_data), 32'(exp_seq));
                exp_seq++;
                n_rd++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                gen_cnt++;
                n_wr++;
            end
        end
        c_srdy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned w0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("rst_c_drdy", 32'(c_drdy), 32'd0);
        check("rst_p_srdy", 32'(p_srdy), 32'd0);
        check("rst_usage", 32'(usage), 32'd0);
        check("rst_p_data", 32'(p_data), 32'd0);
        check("rst_cp_srdy", 32'(cp_srdy), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_c_drdy", 32'(c_drdy), 32'd1);
        check("post_rst_cc_drdy", 32'(cc_drdy), 32'd1);

        clear_stats();
        run(8'hFF, 8'hFF, 50);
        check("t1_words", n_wr, 32'd50);
        check("t1_max_use", max_use, 32'd2);
        run(8'h00, 8'hFF, 5);
        check("t1_drained", n_rd, n_wr);

        clear_stats();
        run(8'h5A, 8'hFF, 20);
        check("t2_words", n_wr, 32'd60);
        check("t2_cdrdy_low", cdrdy_low, 32'd0);
        run(8'h00, 8'hFF, 5);

        clear_stats();
        run(8'h5A, 8'hA5, 40);
        check("t3_words", n_wr, 32'd80);
        check("t3_cdrdy_low", cdrdy_low, 32'd0);
        run(8'h00, 8'hFF, 10);
        check("t3_drained", n_rd, n_wr);

        clear_stats();
        run(8'hFD, 8'hA5, 1000);
        check("t4_max_use", max_use, 32'd256);
        check("t4_full_block", 32'(full_block > 0), 32'd1);
        run(8'h00, 8'hFF, 300);
        check("t4_drained", n_rd, n_wr);
        check("t4_usage0", 32'(usage), 32'd0);

        clear_stats();
        w0 = n_wr;
        run(8'h11, 8'hFF, 40);
        check("t5_words", n_wr - w0, 32'd10);
        check("t5_min_use", min_use, 32'd0);
        check("t5_psrdy_gaps", 32'(psrdy_low > 0), 32'd1);
        run(8'h00, 8'hFF, 5);
        check("t5_empty", 32'(p_srdy), 32'd0);
        check("t5_drained", n_rd, n_wr);

        // Commit/abort instance; dut stays idle but is still checked every cycle.
        p_drdy = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            cc_srdy = 1'b1;
            cc_data = 8'hA0 + 8'(i);
            tick();
            check("t6_uncommitted_usage", 32'(cc_usage), 32'd0);
        end
        cc_srdy = 1'b0;
        cc_abort = 1'b1;
        tick();
        cc_abort = 1'b0;
        check("t6_abort_usage", 32'(cc_usage), 32'd0);
        tick();
        check("t6_abort_psrdy", 32'(cp_srdy), 32'd0);
        for (int unsigned i = 0; i < 4; i++) begin
            cc_srdy   = 1'b1;
            cc_data   = 8'hB0 + 8'(i);
            cc_commit = (i == 3);
            tick();
        end
        cc_srdy = 1'b0;
        cc_commit = 1'b0;
        check("t6_commit_usage", 32'(cc_usage), 32'd4);
        check("t6_commit_psrdy0", 32'(cp_srdy), 32'd0);
        tick();
        check("t6_first_psrdy", 32'(cp_srdy), 32'd1);
        check("t6_first_data", 32'(cp_data), 32'hB0);
        cp_drdy = 1'b1;
        tick();
        check("t6_rd1_data", 32'(cp_data), 32'hB1);
        tick();
        check("t6_rd2_data", 32'(cp_data), 32'hB2);
        cp_drdy = 1'b0;
        cp_abort = 1'b1;
        tick();
        cp_abort = 1'b0;
        check("t6_pabort_psrdy", 32'(cp_srdy), 32'd0);
        check("t6_pabort_usage", 32'(cc_usage), 32'd4);
        tick();
        check("t6_replay_psrdy", 32'(cp_srdy), 32'd1);
        check("t6_replay0", 32'(cp_data), 32'hB0);
        cp_drdy = 1'b1;
        tick();
        check("t6_replay1", 32'(cp_data), 32'hB1);
        cp_commit = 1'b1;
        tick();
        cp_commit = 1'b0;
        cp_drdy = 1'b0;
        check("t6_pcommit_usage", 32'(cc_usage), 32'd2);
        check("t6_pcommit_data", 32'(cp_data), 32'hB2);
        reset = 1'b1;
        tick();
        check("t6_rst_usage", 32'(cc_usage), 32'd0);
        check("t6_rst_psrdy", 32'(cp_srdy), 32'd0);
        check("t6_rst_cdrdy", 32'(cc_drdy), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_post_rst_cdrdy", 32'(cc_drdy), 32'd1);

        run(8'hFF, 8'hFF, 20);
        run(8'h00, 8'hFF, 5);
        check("post_reset_stream", n_rd, n_wr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
